// File: rtl/spi_pnb_recv.sv
// SPI slave receiver (CPOL=0/CPHA=0): oversamples sck/sdi/csn in clk and deserialises DATA_W-bit words.
// Latency: 1 clk from the synchronised sck rising-edge detect to the vld strobe (3 clk from the pin edge).
// No backpressure: dataout holds between vld strobes and the consumer must capture it on vld.
//
// Ports:
//   clk      in   system clock, all logic on its rising edge
//   rst_n    in   asynchronous active-low reset
//   sck      in   SPI clock (async to clk), sampled on its rising edge
//   sdi      in   SPI serial data (async to clk)
//   csn      in   SPI chip select, active low (async to clk)
//   dataout  out  last completed word
//   vld      out  one-cycle strobe, dataout updated this cycle
//   frm_err  out  one-cycle strobe, a partial word was discarded
//   busy     out  high while a csn frame is being received
module spi_pnb_recv #(
    parameter int DATA_W      = 16,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck,
    input  logic              sdi,
    input  logic              csn,
    output logic [DATA_W-1:0] dataout,
    output logic              vld,
    output logic              frm_err,
    output logic              busy
);

    // Bit counter must hold 0..DATA_W-1; timeout counter 0..TIMEOUT_CYC-1.
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers. All three lines go through the same depth so
    // sdi keeps its alignment with sck; sck gets one extra stage for edge
    // detection. csn resets high so a reset never looks like a frame start.
    // ------------------------------------------------------------------
    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic sdi_s1_q, sdi_s2_q;
    logic csn_s1_q, csn_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1_q <= 1'b0;
            sck_s2_q <= 1'b0;
            sck_s3_q <= 1'b0;
            sdi_s1_q <= 1'b0;
            sdi_s2_q <= 1'b0;
            csn_s1_q <= 1'b1;
            csn_s2_q <= 1'b1;
        end else begin
            sck_s1_q <= sck;
            sck_s2_q <= sck_s1_q;
            sck_s3_q <= sck_s2_q;
            sdi_s1_q <= sdi;
            sdi_s2_q <= sdi_s1_q;
            csn_s1_q <= csn;
            csn_s2_q <= csn_s1_q;
        end
    end

    logic sck_rise;
    logic csn_high;

    assign sck_rise = sck_s2_q & ~sck_s3_q;
    assign csn_high = csn_s2_q;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  dataout_q, dataout_d;
    logic               vld_q, vld_d;
    logic               frm_err_q, frm_err_d;

    // Shift register contents including the bit being sampled right now.
    // MSB-first shifts left so the first bit ends up at the top; LSB-first
    // shifts right so the first bit ends up at bit 0.
    logic [DATA_W-1:0] shift_in;

    always_comb begin
        shift_in = shreg_q;
        if (MSB_FIRST != 0) begin
            shift_in = {shreg_q[DATA_W-2:0], sdi_s2_q};
        end else begin
            shift_in = {sdi_s2_q, shreg_q[DATA_W-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority inside SHIFT:
    //   1. final-bit sck_rise completes the word, even if csn is seen high
    //   2. csn high ends the frame; anything partial (including a non-final
    //      bit arriving in this very cycle) is reported as frm_err
    //   3. ordinary sck_rise shifts a bit in
    //   4. otherwise the stall timer runs while a partial word is held
    // This ordering also guarantees vld and frm_err are mutually exclusive.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        shreg_d   = shreg_q;
        dataout_d = dataout_q;
        vld_d     = 1'b0;
        frm_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!csn_high) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                end
            end

            ST_SHIFT: begin
                if (sck_rise && (bit_cnt_q == LAST_BIT)) begin
                    shreg_d   = shift_in;
                    dataout_d = shift_in;
                    vld_d     = 1'b1;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    if (csn_high) begin
                        state_d = ST_IDLE;
                    end
                end else if (csn_high) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    frm_err_d = (bit_cnt_q != '0) || sck_rise;
                end else if (sck_rise) begin
                    shreg_d   = shift_in;
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    tmo_cnt_d = '0;
                end else if (bit_cnt_q != '0) begin
                    // Stalled partial word: abort it but stay in the frame,
                    // so the master can resynchronise without toggling csn.
                    if (tmo_cnt_q == TMO_LAST) begin
                        frm_err_d = 1'b1;
                        bit_cnt_d = '0;
                        tmo_cnt_d = '0;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                    end
                end else begin
                    tmo_cnt_d = '0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                tmo_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            shreg_q   <= '0;
            dataout_q <= '0;
            vld_q     <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            shreg_q   <= shreg_d;
            dataout_q <= dataout_d;
            vld_q     <= vld_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign dataout = dataout_q;
    assign vld     = vld_q;
    assign frm_err = frm_err_q;
    assign busy    = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_pnb_recv.sv
// Bench for spi_pnb_recv: drives one SPI stream into an MSB-first and an LSB-first receiver.
// Expected vld/frm_err events are queued when stimulus is driven and popped when the DUT reports them.
// sck runs at clk/8; inputs are driven on the falling clk edge, outputs sampled there too.
module tb_spi_pnb_recv;

    localparam int DW       = 16;
    localparam int TMO      = 1024;
    localparam int CLK_HALF = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sck;
    logic          sdi;
    logic          csn;
    logic [DW-1:0] dataout_a, dataout_b;
    logic          vld_a, vld_b;
    logic          frm_err_a, frm_err_b;
    logic          busy_a, busy_b;

    spi_pnb_recv #(.DATA_W(DW), .MSB_FIRST(1), .TIMEOUT_CYC(TMO)) u_dut_msb (
        .clk     (clk),
        .rst_n   (rst_n),
        .sck     (sck),
        .sdi     (sdi),
        .csn     (csn),
        .dataout (dataout_a),
        .vld     (vld_a),
        .frm_err (frm_err_a),
        .busy    (busy_a)
    );

    spi_pnb_recv #(.DATA_W(DW), .MSB_FIRST(0), .TIMEOUT_CYC(TMO)) u_dut_lsb (
        .clk     (clk),
        .rst_n   (rst_n),
        .sck     (sck),
        .sdi     (sdi),
        .csn     (csn),
        .dataout (dataout_b),
        .vld     (vld_b),
        .frm_err (frm_err_b),
        .busy    (busy_b)
    );

    always #CLK_HALF clk = ~clk;

    int n_vec      = 0;
    int n_miscmp   = 0;
    int cyc        = 0;
    int last_rise  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            is_err;
        bit            tmo;
        logic [DW-1:0] data;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    // Last completed word per receiver, i.e. what dataout must hold.
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
    endfunction

    // Scoreboard side: called once per receiver on every falling edge.
    task automatic mon(input int which, input logic v, input logic e, input logic [DW-1:0] d);
        ev_t ev;
        bit  have;
        int  lat;
        if (!(v || e)) return;
        check_val("vld_err_excl", {31'b0, v && e}, 32'd0);
        have = (which == 0) ? (qa.size() != 0) : (qb.size() != 0);
        check_val("sb_expected_evt", {31'b0, have}, 32'd1);
        if (!have) return;
        if (which == 0) ev = qa.pop_front();
        else            ev = qb.pop_front();
        lat = cyc - last_rise;
        check_val("evt_kind", {31'b0, e}, {31'b0, ev.is_err});
        if (!ev.is_err) begin
            check_val("dataout", d, ev.data);
            // 2-FF sync + edge stage + output register: 3 clk from pin edge.
            check_val("vld_latency", lat, 32'd3);
        end else if (ev.tmo) begin
            check_val("tmo_latency", {31'b0, (lat >= TMO) && (lat <= TMO + 4)}, 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, vld_a, frm_err_a, dataout_a);
            mon(1, vld_b, frm_err_b, dataout_b);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sck = 1'b0;
        sdi = b;
        wait_cyc(4);
        sck = 1'b1;
        last_rise = cyc;
        wait_cyc(3);
    endtask

    // Transmit the top n bits of w, MSB first on the wire.
    task automatic send_bits(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(w[DW-1-i]);
    endtask

    task automatic push_err(input bit tmo);
        qa.push_back('{is_err: 1'b1, tmo: tmo, data: '0});
        qb.push_back('{is_err: 1'b1, tmo: tmo, data: '0});
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        qa.push_back('{is_err: 1'b0, tmo: 1'b0, data: w});
        qb.push_back('{is_err: 1'b0, tmo: 1'b0, data: bitrev(w)});
        send_bits(w, DW);
        last_a = w;
        last_b = bitrev(w);
    endtask

    task automatic frame_start();
        @(negedge clk);
        sck = 1'b0;
        csn = 1'b0;
        wait_cyc(4);
        check_val("busy_after_csn_low", {31'b0, busy_a}, 32'd1);
    endtask

    task automatic frame_end(input bit expect_err);
        @(negedge clk);
        sck = 1'b0;
        wait_cyc(3);
        check_val("busy_before_csn_high", {31'b0, busy_b}, 32'd1);
        if (expect_err) push_err(1'b0);
        csn = 1'b1;
        wait_cyc(6);
        check_val("busy_after_csn_high", {31'b0, busy_a}, 32'd0);
        check_val("dout_hold_msb", dataout_a, last_a);
        check_val("dout_hold_lsb", dataout_b, last_b);
    endtask

    initial begin
        rst_n = 1'b0;
        sck   = 1'b0;
        sdi   = 1'b0;
        csn   = 1'b1;
        wait_cyc(3);
        #1;
        check_val("rst_dataout", dataout_a, 32'd0);
        check_val("rst_vld", {31'b0, vld_a}, 32'd0);
        check_val("rst_frm_err", {31'b0, frm_err_a}, 32'd0);
        check_val("rst_busy", {31'b0, busy_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(4);

        // Single word; LSB-first receiver sees the bit-reversed value.
        frame_start();
        send_word(16'hA5C3);
        frame_end(1'b0);

        // Back-to-back words in one frame.
        frame_start();
        send_word(16'h1234);
        send_word(16'hFFFF);
        send_word(16'h0000);
        frame_end(1'b0);

        // csn raised after 7 bits: frm_err only, dataout keeps 0x0000.
        frame_start();
        send_bits(16'hB6DB, 7);
        frame_end(1'b1);

        // Exactly 16 bits then csn high: vld only.
        frame_start();
        send_word(16'h6A59);
        frame_end(1'b0);

        // 5 bits then a stall: timeout abort, frame continues.
        frame_start();
        send_bits(16'hF800, 5);
        push_err(1'b1);
        @(negedge clk);
        sck = 1'b0;
        wait_cyc(TMO + 40);
        check_val("busy_after_timeout", {31'b0, busy_a}, 32'd1);
        check_val("dout_after_timeout", dataout_a, last_a);
        send_word(16'h0F0F);
        frame_end(1'b0);

        // Reset in the middle of a word.
        frame_start();
        send_bits(16'hFFFF, 9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_dataout", dataout_a, 32'd0);
        check_val("midrst_vld", {31'b0, vld_a}, 32'd0);
        check_val("midrst_frm_err", {31'b0, frm_err_b}, 32'd0);
        check_val("midrst_busy", {31'b0, busy_a}, 32'd0);
        last_a = '0;
        last_b = '0;
        csn = 1'b1;
        sck = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(4);
        check_val("postrst_dataout", dataout_b, 32'd0);
        frame_start();
        send_word(16'hBEEF);
        frame_end(1'b0);

        wait_cyc(20);
        check_val("sb_drained_msb", qa.size(), 32'd0);
        check_val("sb_drained_lsb", qb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
